// File: rtl/led_activity_gen_if.sv
// Bundle of per-port PHY/MAC status inputs and LED-driver outputs for led_activity_gen.
// The slave modport is the generator itself; the master side feeds it and consumes the LED triple.
interface led_activity_gen_if #(
    parameter int NPORTS = 8
);
    logic [NPORTS-1:0] link_up_raw;
    logic [NPORTS-1:0] rx_pulse;
    logic [NPORTS-1:0] tx_pulse;
    logic [NPORTS-1:0] link;
    logic [NPORTS-1:0] act;
    logic              blink;
    logic              tick;

    modport master (
        output link_up_raw,
        output rx_pulse,
        output tx_pulse,
        input  link,
        input  act,
        input  blink,
        input  tick
    );

    modport slave (
        input  link_up_raw,
        input  rx_pulse,
        input  tx_pulse,
        output link,
        output act,
        output blink,
        output tick
    );
endinterface

// File: rtl/led_activity_gen.sv
// Turns asynchronous PHY link status and MAC rx/tx pulses into registered link/act/blink
// LED controls, with per-port link debounce, activity stretching and a shared blink prescaler.
module led_activity_gen #(
    parameter int NPORTS   = 8,
    parameter int PRESCALE = 2500000,
    parameter int STRETCH  = 3,
    parameter int DEBOUNCE = 2
) (
    input  logic                clk,
    input  logic                rst,
    led_activity_gen_if.slave   bus
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int SW = $clog2(STRETCH + 1);
    localparam int DW = $clog2(DEBOUNCE + 1);

    logic [PW-1:0]     r_presc;
    logic              r_blink;
    logic [NPORTS-1:0] r_syncMeta;
    logic [NPORTS-1:0] r_ls;
    logic [NPORTS-1:0] r_acc;
    logic [DW-1:0]     r_deb [NPORTS];
    logic [SW-1:0]     r_sc  [NPORTS];
    logic [NPORTS-1:0] r_link;
    logic [NPORTS-1:0] r_act;

    logic              w_tick;
    logic [NPORTS-1:0] w_accNext;
    logic [DW-1:0]     w_debNext [NPORTS];
    logic [SW-1:0]     w_scNext  [NPORTS];

    assign w_tick = (r_presc == PW'(PRESCALE - 1));

    // Next-state for each port; the stretch counter looks at the post-acceptance link state so a
    // link drop clears it on the very edge the drop is accepted.
    always_comb begin
        for (int i = 0; i < NPORTS; i++) begin
            w_accNext[i] = r_acc[i];
            w_debNext[i] = r_deb[i];
            w_scNext[i]  = r_sc[i];

            if (r_ls[i] == r_acc[i]) begin
                w_debNext[i] = '0;
            end else if (w_tick) begin
                if (r_deb[i] == DW'(DEBOUNCE - 1)) begin
                    w_accNext[i] = r_ls[i];
                    w_debNext[i] = '0;
                end else begin
                    w_debNext[i] = r_deb[i] + 1'b1;
                end
            end

            if (!w_accNext[i]) begin
                w_scNext[i] = '0;
            end else if (bus.rx_pulse[i] || bus.tx_pulse[i]) begin
                w_scNext[i] = SW'(STRETCH);
            end else if (w_tick && (r_sc[i] != '0)) begin
                w_scNext[i] = r_sc[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
            r_blink <= 1'b0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            if (w_tick) begin
                r_blink <= ~r_blink;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_syncMeta <= '0;
            r_ls       <= '0;
            r_acc      <= '0;
            r_link     <= '1;
            r_act      <= '0;
            for (int i = 0; i < NPORTS; i++) begin
                r_deb[i] <= '0;
                r_sc[i]  <= '0;
            end
        end else begin
            r_syncMeta <= bus.link_up_raw;
            r_ls       <= r_syncMeta;
            r_acc      <= w_accNext;
            for (int i = 0; i < NPORTS; i++) begin
                r_deb[i]  <= w_debNext[i];
                r_sc[i]   <= w_scNext[i];
                r_link[i] <= ~r_acc[i];
                r_act[i]  <= r_acc[i] & (r_sc[i] == '0);
            end
        end
    end

    assign bus.link  = r_link;
    assign bus.act   = r_act;
    assign bus.blink = r_blink;
    assign bus.tick  = w_tick;

endmodule
